// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit arbiter
// Purpose: arbiter state encoding, protocol byte constants and the baud divisor helper.
// Optional feature macro: UART_ARB_TAG_EN (adds the TAG state and the tag base byte).
package uart_pkg;

`ifdef UART_ARB_TAG_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_SEND = 2'd2,
        ST_TAG  = 2'd3
    } arb_state_e;

    // Tag byte is this value plus the granted requester index ('0' or '1').
    localparam logic [7:0] UART_TAG_BASE = 8'h30;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_SEND = 2'd2
    } arb_state_e;
`endif

    // Line terminator: a granted requester keeps the line until it sends one.
    localparam logic [7:0] UART_NL = 8'h0A;

    // Clock cycles per bit, truncated.
    function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_ser.sv
// rtl/uart_tx_ser.sv - 8N1 serialiser with integrated baud divider
// Purpose: shifts one byte out as start bit, 8 data bits LSB first, stop bit.
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset; aborts any frame, tx idles high next cycle
//   start in   load data and begin a frame (ignored while busy)
//   data  in   byte to send, sampled with start
//   busy  out  high from the cycle after start through the last stop-bit cycle
//   tx    out  serial line, idle high
module uart_tx_ser #(
    parameter int unsigned DIV = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int unsigned     DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       bit_q, bit_d;
    logic [9:0]       frame_q, frame_d;
    logic             busy_q, busy_d;

    always_comb begin
        div_d   = div_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        busy_d  = busy_q;
        if (start && !busy_q) begin
            frame_d = {1'b1, data, 1'b0};
            div_d   = '0;
            bit_d   = '0;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                // Shifting in ones leaves the line idle-high once the frame is done.
                frame_d = {1'b1, frame_q[9:1]};
                if (bit_q == 4'd9) begin
                    busy_d = 1'b0;
                    bit_d  = '0;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            bit_q   <= '0;
            frame_q <= '1;
            busy_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign tx   = frame_q[0];

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - two-requester UART transmit arbiter with line-granular locking
// Purpose: grants the tx pin to the CPU console (0) or debug port (1), holds the grant
//   until a newline is sent or the owner stays idle for HOLD_CYCLES, and serialises 8N1.
// Optional feature macro: UART_ARB_TAG_EN (emit '0'/'1' tag byte at the start of each grant).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req0_valid/data/ready          CPU console byte stream
//   req1_valid/data/ready          debug port byte stream
//   grant                          current owner, meaningful while locked
//   locked                         a requester owns the line
//   tx                             serial output, idle high
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 24000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned HOLD_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       grant,
    output logic       locked,
    output logic       tx
);

    localparam int unsigned DIV          = uart_div(CLK_HZ, BAUD);
    localparam int unsigned FRAME_CYCLES = 10 * DIV;
    localparam int unsigned CNT_MAX      = (HOLD_CYCLES > FRAME_CYCLES) ? HOLD_CYCLES : FRAME_CYCLES;
    localparam int unsigned CNT_W        = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_arb: CLK_HZ / BAUD must be at least 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("uart_tx_arb: HOLD_CYCLES must be at least 1");
    end

    arb_state_e       state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       byte_q, byte_d;

    logic             sel;
    logic             owner_valid;
    logic [7:0]       owner_data;
    logic             accept;
    logic             ser_start;
    logic [7:0]       ser_data;
    logic             ser_busy;

    assign owner_valid = grant_q ? req1_valid : req0_valid;
    assign owner_data  = grant_q ? req1_data  : req0_data;
    // Round-robin on a tie; a lone requester always wins.
    assign sel = (req0_valid && req1_valid) ? ~last_q : req1_valid;

    // cnt_q counts idle cycles in LOCK and elapsed frame cycles in SEND. The frame
    // count lets SEND end on the last stop-bit cycle so the next byte costs one gap cycle.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        byte_d    = byte_q;
        accept    = 1'b0;
        ser_start = 1'b0;
        ser_data  = byte_q;
        case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_d = sel;
                    last_d  = sel;
                    cnt_d   = '0;
`ifdef UART_ARB_TAG_EN
                    state_d = ST_TAG;
`else
                    state_d = ST_LOCK;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG: begin
                ser_start = 1'b1;
                ser_data  = UART_TAG_BASE | {7'd0, grant_q};
                byte_d    = UART_TAG_BASE | {7'd0, grant_q};
                cnt_d     = '0;
                state_d   = ST_SEND;
            end
`endif
            ST_LOCK: begin
                if (owner_valid && !ser_busy) begin
                    accept    = 1'b1;
                    ser_start = 1'b1;
                    ser_data  = owner_data;
                    byte_d    = owner_data;
                    cnt_d     = '0;
                    state_d   = ST_SEND;
                end else if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SEND: begin
                if (cnt_q == FRAME_LAST) begin
                    cnt_d   = '0;
                    state_d = (byte_q == UART_NL) ? ST_IDLE : ST_LOCK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
        end
    end

    assign req0_ready = accept && !grant_q;
    assign req1_ready = accept &&  grant_q;
    assign grant      = grant_q;
    assign locked     = (state_q != ST_IDLE);

    uart_tx_ser #(
        .DIV (DIV)
    ) u_ser (
        .clk   (clk),
        .rst   (rst),
        .start (ser_start),
        .data  (ser_data),
        .busy  (ser_busy),
        .tx    (tx)
    );

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Shares the single UART transmit pin between two byte-stream requesters: the CPU console port and the debug/trace port. The block arbitrates between them with line-granular locking, so one requester's text is never interleaved mid-line with the other's. It serialises each granted byte as 8N1. It sits in `machine` between the two requesters and the `uart_tx` pad.

## Interface
Parameters:
- `CLK_HZ`, default 24000000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate in baud.
- `HOLD_CYCLES`, default 1024: number of idle cycles the grant is held while the owner has no byte pending.

Ports:
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req0_valid`  in  1: CPU console has a byte to send.
- `req0_data`  in  8: CPU console byte.
- `req0_ready`  out  1: CPU console byte accepted this cycle.
- `req1_valid`  in  1: debug port has a byte to send.
- `req1_data`  in  8: debug port byte.
- `req1_ready`  out  1: debug port byte accepted this cycle.
- `grant`  out  1: current owner (0 = CPU console, 1 = debug port); meaningful only while `locked` is high.
- `locked`  out  1: a requester currently owns the line.
- `tx`  out  1: UART serial output, idle high.

## Operation
- Handshake:
  - A byte transfers when `reqN_valid && reqN_ready`.
  - A requester must hold `valid` and `data` stable until `ready`.
  - `ready` is a single-cycle pulse, only ever asserted to the owner.
- States:
  - IDLE:
    - No owner.
    - If exactly one requester is valid, grant to it.
    - If both are valid, grant to the requester not granted last (round-robin).
    - Go to LOCK.
  - LOCK:
    - If the owner is valid and the serialiser is idle, pulse `ready`, latch the byte and go to SEND.
    - Otherwise count idle cycles.
    - When the count reaches `HOLD_CYCLES`, release to IDLE.
  - SEND:
    - The serialiser is shifting.
    - When the frame completes: if the byte was 8'h0A, release to IDLE; otherwise return to LOCK and clear the idle counter.
  - TAG: exists only with `UART_ARB_TAG_EN`; see Configuration.
- Serialiser frame: start bit 0, data bits LSB first, stop bit 1.
- Bit period: `DIV = CLK_HZ / BAUD`, integer-truncated.
  - Elaboration error if `DIV < 2`.
  - The divider counter is `$clog2(DIV)` bits wide and wraps at `DIV-1`.
- Last-grant pointer resets to 1, so req0 wins the first tie.
- Both requesters valid while one is locked: the other waits. No preemption.
- Owner deasserts `valid` mid-lock: the idle counter runs. Reasserting it before `HOLD_CYCLES` keeps the grant.
- Reset mid-frame: the frame is aborted and `tx` returns to 1 on the next cycle. This can produce a truncated frame; that is acceptable.

## Timing
- Reset values: `tx=1`, `req0_ready=0`, `req1_ready=0`, `locked=0`, `grant=0`, state IDLE, last-grant pointer 1, all counters 0.
- Grant latency: IDLE with valid at cycle N gives `locked=1` at N+1. The earliest `ready` is at N+1, a combinational pulse from LOCK state.
- Accept at cycle M: start bit on `tx` from M+1.
- One frame lasts exactly `10*DIV` cycles.
- Back-to-back bytes from the owner: 1 gap cycle (LOCK) between stop bit and next start bit.
- Throughput: one byte per `10*DIV+1` cycles.
- Release on newline: IDLE in the cycle after the stop bit ends. A new grant follows in the next cycle.

## Configuration
- Macro `UART_ARB_TAG_EN`.
- When defined:
  - On every transition IDLE→LOCK, the block first emits a tag byte, ASCII `'0'+grant` (8'h30 or 8'h31), through the TAG state.
  - No `ready` pulse is given for the tag.
  - The tag adds `10*DIV+1` cycles before the first owner byte.
- When undefined:
  - The TAG state, its logic and its constant are absent.
  - IDLE goes directly to LOCK.

## Structure
- Package `uart_pkg`:
  - State enum (IDLE, LOCK, SEND, TAG).
  - Constant `UART_NL = 8'h0A`.
  - Constant `UART_TAG_BASE = 8'h30`.
  - Function computing `DIV` from `CLK_HZ` and `BAUD`.
- Sub-module `uart_tx_ser`:
  - 8N1 shifter and baud divider.
  - Ports: `clk`, `rst`, `start`, `data[7:0]`, `busy`, `tx`.
  - `busy` is high from the cycle after `start` through the end of the stop bit.
- Arbitration and the FSM stay in `uart_tx_arb`.

## Test plan
All scenarios use `CLK_HZ=1000000`, `BAUD=100000` (DIV=10, frame 100 cycles), `HOLD_CYCLES=20`.
- Single byte: req0 sends 8'h41 → `tx` reads 0,1,0,0,0,0,0,1,0,1, each bit held 10 cycles. `req0_ready` pulses once.
- Tie after reset: req0 and req1 both valid → req0 granted first. After req0's "A\n", req1 is granted and both streams appear unmixed on `tx`.
- Line lock: req0 sends "AB\n" while req1 is valid throughout → `req1_ready` stays 0 until the 8'h0A stop bit ends. Then req1 is granted within 2 cycles.
- Hold timeout: req0 sends 8'h41 and then drops `valid` for 20 cycles → `locked` falls at the 20th idle cycle. A pending req1 is granted the next cycle.
- Reset mid-frame: assert `rst` 35 cycles into a frame → `tx=1` and `locked=0` next cycle. A new byte afterwards serialises correctly.
- Tag (with `UART_ARB_TAG_EN`): req1 sends 8'h41 → frames 8'h31 then 8'h41 on `tx`. `req1_ready` pulses once, at cycle 101 after the grant.
